// File: rtl/fu_dispatch_scheduler.sv
// Credit-based round-robin FU assignment for the unified issue queue, with flush drain.
// Optional macro FU_SCHED_STATS_EN adds a saturating dispatch-stall cycle counter.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal dispatch, selections granted while credit remains
// ST_DRAIN | flush seen, dispatch closed until every FU count is zero
module fu_dispatch_scheduler #(
  parameter int FU_SIZE      = 2,
  parameter int FU_ARRAY     = 3,
  parameter int CREDIT_DEPTH = 4,
  parameter int CNT_W        = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      disp_valid_in,
  input  logic                      disp_is_mem_in,
  output logic                      disp_ready_out,
  output logic                      grant_valid_out,
  output logic [FU_SIZE-1:0]        fu_number_out,
  input  logic [FU_ARRAY-1:0]       complete_in,
  input  logic                      flush_in,
  output logic                      draining_out,
  output logic [FU_ARRAY*CNT_W-1:0] credits_out,
  output logic                      err_out
`ifdef FU_SCHED_STATS_EN
  ,
  output logic [15:0]               stall_cycles_out
`endif
);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  localparam int                 N_ALU  = FU_ARRAY - 1;
  localparam logic [FU_SIZE-1:0] MEM_FU = FU_SIZE'(FU_ARRAY - 1);
  localparam logic [FU_SIZE-1:0] LAST_A = FU_SIZE'(N_ALU - 1);
  localparam logic [CNT_W-1:0]   DEPTH  = CNT_W'(CREDIT_DEPTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [FU_ARRAY];
  logic [CNT_W-1:0]   cnt_d [FU_ARRAY];
  logic [FU_SIZE-1:0] ptr_q, ptr_d;
  logic [FU_SIZE-1:0] fu_q, fu_d;
  logic               gv_q, gv_d;
  logic               err_q, err_d;
  logic [FU_SIZE-1:0] sel;
  logic [FU_SIZE-1:0] alu_idx;
  logic [FU_SIZE:0]   alu_sum;
  logic               found;
  logic               accept;
  logic               all_idle;

  // ALU search starts at the pointer and wraps within the ALU subset only
  always_comb begin
    sel     = '0;
    found   = 1'b0;
    alu_sum = '0;
    alu_idx = '0;
    if (disp_is_mem_in) begin
      sel   = MEM_FU;
      found = (cnt_q[FU_ARRAY-1] < DEPTH);
    end else begin
      for (int k = 0; k < N_ALU; k++) begin
        alu_sum = {1'b0, ptr_q} + (FU_SIZE+1)'(k);
        if (alu_sum >= (FU_SIZE+1)'(N_ALU)) alu_sum = alu_sum - (FU_SIZE+1)'(N_ALU);
        alu_idx = alu_sum[FU_SIZE-1:0];
        if (!found && (cnt_q[alu_idx] < DEPTH)) begin
          found = 1'b1;
          sel   = alu_idx;
        end
      end
    end
  end

  assign disp_ready_out = (state_q == ST_RUN) && found && !flush_in;
  assign accept         = disp_valid_in && disp_ready_out;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    fu_d     = fu_q;
    gv_d     = accept;
    err_d    = err_q;
    all_idle = 1'b1;
    for (int i = 0; i < FU_ARRAY; i++) begin
      cnt_d[i] = cnt_q[i];
      if (complete_in[i]) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_d[i] - CNT_W'(1);
        else                err_d    = 1'b1;
      end
      if (accept && (sel == FU_SIZE'(i))) cnt_d[i] = cnt_d[i] + CNT_W'(1);
      if (cnt_d[i] != '0) all_idle = 1'b0;
    end
    if (accept) begin
      fu_d = sel;
      if (!disp_is_mem_in) ptr_d = (sel == LAST_A) ? '0 : sel + FU_SIZE'(1);
    end
    case (state_q)
      ST_RUN:   if (flush_in) state_d = ST_DRAIN;
      ST_DRAIN: if (all_idle) begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      fu_q    <= '0;
      gv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < FU_ARRAY; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fu_q    <= fu_d;
      gv_q    <= gv_d;
      err_q   <= err_d;
      for (int i = 0; i < FU_ARRAY; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < FU_ARRAY; g++) begin : g_credits
    assign credits_out[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign grant_valid_out = gv_q;
  assign fu_number_out   = fu_q;
  assign err_out         = err_q;
  assign draining_out    = (state_q == ST_DRAIN);

`ifdef FU_SCHED_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (disp_valid_in && !disp_ready_out && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles_out = stall_q;
`endif

endmodule
